// File: rtl/lcd_pkg.sv
// +----------------------------------------------------------------------+
// | lcd_pkg: shared constants, opcode masks and FSM state type for the   |
// | HD44780-style character LCD blocks.                   Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

package lcd_pkg;

  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] ONE   = 8'h31;
  localparam logic [7:0] TWO   = 8'h32;
  localparam logic [7:0] THREE = 8'h33;
  localparam logic [7:0] FOUR  = 8'h34;
  localparam logic [7:0] FIVE  = 8'h35;
  localparam logic [7:0] SIX   = 8'h36;
  localparam logic [7:0] SEVEN = 8'h37;
  localparam logic [7:0] EIGHT = 8'h38;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] EQU   = 8'h3D;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;

  localparam int CELLS = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    CLEARING = 2'd2
  } lcd_state_e;

  // Two 16-column lines: stepping off the end of one line lands on the other.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac[3:0] == 4'hF) nxt = ac[6] ? LINE0_BASE : LINE1_BASE;
      else                 nxt = ac + 7'd1;
    end else begin
      if (ac[3:0] == 4'h0) nxt = ac[6] ? (LINE0_BASE | 7'h0F) : (LINE1_BASE | 7'h0F);
      else                 nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  function automatic logic [4:0] ac_index(input logic [6:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_edge_sync.sv
// +----------------------------------------------------------------------+
// | lcd_edge_sync: 2-flop synchroniser for the LCD bus with E rise/fall  |
// | pulse generation.                                     Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module lcd_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic       e_rise,
  output logic       e_fall,
  output logic       rs_s,
  output logic       rw_s,
  output logic [7:0] data_s
);

  logic [10:0] meta_q, meta_d;
  logic [10:0] sync_q, sync_d;
  logic        e_prev_q, e_prev_d;

  always_comb begin
    meta_d   = {lcd_e, lcd_rs, lcd_rw, lcd_data};
    sync_d   = meta_q;
    e_prev_d = sync_q[10];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      e_prev_q <= 1'b0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      e_prev_q <= e_prev_d;
    end
  end

  assign e_rise = sync_q[10] & ~e_prev_q;
  assign e_fall = ~sync_q[10] & e_prev_q;
  assign rs_s   = sync_q[9];
  assign rw_s   = sync_q[8];
  assign data_s = sync_q[7:0];

endmodule

`default_nettype wire

// File: rtl/lcd_char_sink.sv
// +----------------------------------------------------------------------+
// | lcd_char_sink: responder side of an HD44780-style 8-bit LCD bus that |
// | mirrors the 2x16 DDRAM image.                         Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module lcd_char_sink
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 40  // must cover the 32 one-cell-per-cycle clear writes
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_dout,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       disp_on,
  output logic       proto_err,
  output logic [6:0] ac
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic       e_rise, e_fall, rs_s, rw_s;
  logic [7:0] data_s;

  lcd_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .e_rise   (e_rise),
    .e_fall   (e_fall),
    .rs_s     (rs_s),
    .rw_s     (rw_s),
    .data_s   (data_s)
  );

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       clr_idx_q, clr_idx_d;
  logic             busy_q, busy_d;
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             disp_on_q, disp_on_d;
  logic [1:0]       cb_q, cb_d;
  logic [1:0]       nf_q, nf_d;
  logic             proto_err_q, proto_err_d;
  logic [7:0]       lcd_dout_q, lcd_dout_d;
  logic [7:0]       rd_char_q, rd_char_d;
  logic [7:0]       ddram_q [CELLS];
  logic [7:0]       ddram_d [CELLS];
  logic             wr_xfer;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_idx_d   = clr_idx_q;
    ac_d        = ac_q;
    id_d        = id_q;
    disp_on_d   = disp_on_q;
    cb_d        = cb_q;
    nf_d        = nf_q;
    proto_err_d = proto_err_q;
    lcd_dout_d  = lcd_dout_q;
    ddram_d     = ddram_q;
    wr_xfer     = e_fall & ~rw_s;

    case (state_q)
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CLEARING: begin
        if (!clr_idx_q[5]) begin
          ddram_d[clr_idx_q[4:0]] = BLANK;
          clr_idx_d               = clr_idx_q + 6'd1;
        end
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    if (e_rise && rw_s)
      lcd_dout_d = rs_s ? ddram_q[ac_index(ac_q)] : {busy_q, ac_q};
    if (e_fall && rw_s && rs_s)
      ac_d = ac_step(ac_q, id_q);

    // busy_q is still 1 in the cycle the countdown expires, so that write loses.
    if (wr_xfer && busy_q) begin
      proto_err_d = 1'b1;
    end else if (wr_xfer && rs_s) begin
      ddram_d[ac_index(ac_q)] = data_s;
      ac_d    = ac_step(ac_q, id_q);
      state_d = BUSY;
      cnt_d   = CNT_W'(BUSY_CYCLES - 1);
    end else if (wr_xfer) begin
      state_d = BUSY;
      cnt_d   = CNT_W'(BUSY_CYCLES - 1);
      if (|(data_s & CMD_SET_DDRAM)) begin
        ac_d = {data_s[6], 2'b00, data_s[3:0]};
        if (|data_s[5:4]) proto_err_d = 1'b1;
      end else if (|(data_s & CMD_SET_CGRAM)) begin
        ac_d = ac_q;
      end else if (|(data_s & CMD_FUNC_SET)) begin
        nf_d = data_s[3:2];
        if (!data_s[4]) proto_err_d = 1'b1;
      end else if (|(data_s & CMD_SHIFT)) begin
        if (!data_s[3]) ac_d = ac_step(ac_q, data_s[2]);
      end else if (|(data_s & CMD_DISP_CTRL)) begin
        disp_on_d = data_s[2];
        cb_d      = data_s[1:0];
      end else if (|(data_s & CMD_ENTRY)) begin
        id_d = data_s[1];
        if (data_s[0]) proto_err_d = 1'b1;
      end else if (|(data_s & CMD_HOME)) begin
        ac_d  = LINE0_BASE;
        cnt_d = CNT_W'(CLEAR_CYCLES - 1);
      end else if (|(data_s & CMD_CLEAR)) begin
        ac_d      = LINE0_BASE;
        id_d      = 1'b1;
        state_d   = CLEARING;
        cnt_d     = CNT_W'(CLEAR_CYCLES - 1);
        clr_idx_d = 6'd0;
      end else begin
        state_d = state_q;
        cnt_d   = cnt_q;
      end
    end

    busy_d    = (state_d != IDLE);
    rd_char_d = ddram_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clr_idx_q   <= '0;
      busy_q      <= 1'b0;
      ac_q        <= '0;
      id_q        <= 1'b1;
      disp_on_q   <= 1'b0;
      cb_q        <= '0;
      nf_q        <= '0;
      proto_err_q <= 1'b0;
      lcd_dout_q  <= '0;
      rd_char_q   <= '0;
      for (int i = 0; i < CELLS; i++) ddram_q[i] <= BLANK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_idx_q   <= clr_idx_d;
      busy_q      <= busy_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_on_q   <= disp_on_d;
      cb_q        <= cb_d;
      nf_q        <= nf_d;
      proto_err_q <= proto_err_d;
      lcd_dout_q  <= lcd_dout_d;
      rd_char_q   <= rd_char_d;
      ddram_q     <= ddram_d;
    end
  end

  assign lcd_dout  = lcd_dout_q;
  assign rd_char   = rd_char_q;
  assign busy      = busy_q;
  assign disp_on   = disp_on_q;
  assign proto_err = proto_err_q;
  assign ac        = ac_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_char_sink.sv
// +----------------------------------------------------------------------+
// | tb_lcd_char_sink: scoreboard bench for lcd_char_sink.                |
// |                                                       Revision: 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lcd_char_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [7:0] lcd_dout;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       busy;
  logic       disp_on;
  logic       proto_err;
  logic [6:0] ac;

  lcd_char_sink dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .lcd_dout  (lcd_dout),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .busy      (busy),
    .disp_on   (disp_on),
    .proto_err (proto_err),
    .ac        (ac)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } cell_exp_t;

  cell_exp_t  sb[$];
  logic [7:0] dq[$];
  int         n_vec = 0;
  int         n_miss = 0;

  // Reference model: cursor as a linear position 0..31 across both lines.
  logic [7:0] mdl_mem [32];
  int         mdl_pos;
  bit         mdl_id;

  function automatic logic [6:0] pos2ac(input int p);
    return (p < 16) ? 7'(p) : 7'(p - 16 + 'h40);
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_mem[i] = 8'h20;
    mdl_pos = 0;
    mdl_id  = 1'b1;
  endtask

  task automatic mdl_step();
    mdl_pos = mdl_id ? (mdl_pos + 1) % 32 : (mdl_pos + 31) % 32;
  endtask

  task automatic lcd_raw(input bit rs, input bit rw, input logic [7:0] d,
                         input int hold, input int gap);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (hold) @(negedge clk);
    lcd_e = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic lcd_wr(input bit rs, input logic [7:0] d, input int gap);
    cell_exp_t e;
    if (rs) begin
      mdl_mem[mdl_pos] = d;
      e.idx = mdl_pos; e.val = d;
      sb.push_back(e);
      mdl_step();
    end else if (d[7]) begin
      mdl_pos = (d[6] ? 16 : 0) + int'(d[3:0]);
    end else if (d[7:2] == 6'b000001) begin
      mdl_id = d[1];
    end else if (d == 8'h01) begin
      mdl_reset();
    end
    lcd_raw(rs, 1'b0, d, 4, gap);
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    rd_addr = 5'(idx);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic test_reset();
    cell_exp_t  e;
    logic [7:0] v;
    rst = 1'b1;
    mdl_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0)      begin n_miss++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (disp_on !== 1'b0)   begin n_miss++; $display("FAIL reset_disp_on got=%b exp=0", disp_on); end
    n_vec++; if (proto_err !== 1'b0) begin n_miss++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    n_vec++; if (ac !== 7'h00)       begin n_miss++; $display("FAIL reset_ac got=%h exp=00", ac); end
    n_vec++; if (lcd_dout !== 8'h00) begin n_miss++; $display("FAIL reset_dout got=%h exp=00", lcd_dout); end
    n_vec++; if (rd_char !== 8'h00)  begin n_miss++; $display("FAIL reset_rd_char got=%h exp=00", rd_char); end
    rst = 1'b0;
    @(negedge clk);
    foreach (mdl_mem[i]) if (i % 5 == 0) begin e.idx = i; e.val = mdl_mem[i]; sb.push_back(e); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL reset_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_init_text();
    cell_exp_t  e;
    logic [7:0] v;
    logic [7:0] txt [6] = '{8'h33, 8'h2B, 8'h34, 8'h3D, 8'h30, 8'h37};
    lcd_wr(0, 8'h3C, 12);
    lcd_wr(0, 8'h0C, 12);
    lcd_wr(0, 8'h06, 12);
    lcd_wr(0, 8'h80, 12);
    foreach (txt[i]) lcd_wr(1, txt[i], 12);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL text_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
    n_vec++; if (ac !== 7'h06)       begin n_miss++; $display("FAIL text_ac got=%h exp=06", ac); end
    n_vec++; if (disp_on !== 1'b1)   begin n_miss++; $display("FAIL text_disp_on got=%b exp=1", disp_on); end
    n_vec++; if (proto_err !== 1'b0) begin n_miss++; $display("FAIL text_proto_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_readback();
    logic [7:0] x;
    dq.push_back({1'b0, pos2ac(mdl_pos)});
    lcd_raw(0, 1, 8'h00, 6, 12);
    x = dq.pop_front();
    n_vec++; if (lcd_dout !== x) begin n_miss++; $display("FAIL status_read got=%h exp=%h", lcd_dout, x); end
    lcd_wr(0, 8'h80, 12);
    dq.push_back(mdl_mem[mdl_pos]);
    mdl_step();
    lcd_raw(1, 1, 8'h00, 6, 12);
    x = dq.pop_front();
    n_vec++; if (lcd_dout !== x) begin n_miss++; $display("FAIL data_read got=%h exp=%h", lcd_dout, x); end
    n_vec++; if (ac !== 7'h01)   begin n_miss++; $display("FAIL data_read_ac got=%h exp=01", ac); end
  endtask

  task automatic test_wrap();
    cell_exp_t  e;
    logic [7:0] v;
    lcd_wr(0, 8'h8F, 12);
    lcd_wr(1, 8'h41, 12);
    lcd_wr(1, 8'h42, 12);
    n_vec++; if (ac !== 7'h41) begin n_miss++; $display("FAIL wrap_inc_ac got=%h exp=41", ac); end
    lcd_wr(0, 8'h04, 12);
    lcd_wr(1, 8'h43, 12);
    n_vec++; if (ac !== 7'h40) begin n_miss++; $display("FAIL wrap_dec_ac got=%h exp=40", ac); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL wrap_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_busy_violation();
    cell_exp_t  e;
    logic [7:0] v;
    lcd_wr(0, 8'h06, 12);
    lcd_wr(0, 8'h80, 1);
    lcd_raw(1, 0, 8'h5A, 2, 12);
    e.idx = 0; e.val = mdl_mem[0]; sb.push_back(e);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL viol_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
    n_vec++; if (proto_err !== 1'b1) begin n_miss++; $display("FAIL viol_proto_err got=%b exp=1", proto_err); end
    n_vec++; if (ac !== 7'h00)       begin n_miss++; $display("FAIL viol_ac got=%h exp=00", ac); end
    lcd_wr(0, 8'h06, 12);
    n_vec++; if (proto_err !== 1'b1) begin n_miss++; $display("FAIL viol_sticky got=%b exp=1", proto_err); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    @(negedge clk);
    n_vec++; if (proto_err !== 1'b0) begin n_miss++; $display("FAIL viol_cleared got=%b exp=0", proto_err); end
  endtask

  task automatic test_bad_address();
    lcd_wr(0, 8'hA5, 12);
    n_vec++; if (proto_err !== 1'b1) begin n_miss++; $display("FAIL badaddr_proto_err got=%b exp=1", proto_err); end
    n_vec++; if (ac !== 7'h05)       begin n_miss++; $display("FAIL badaddr_ac got=%h exp=05", ac); end
    n_vec++; if (ac !== pos2ac(mdl_pos)) begin n_miss++; $display("FAIL badaddr_model_ac got=%h exp=%h", ac, pos2ac(mdl_pos)); end
  endtask

  task automatic test_clear();
    cell_exp_t  e;
    logic [7:0] v;
    int         hi;
    lcd_wr(0, 8'h06, 12);
    lcd_wr(0, 8'h80, 12);
    for (int i = 0; i < 32; i++) lcd_wr(1, 8'(8'h40 + i), 12);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL fill_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
    lcd_wr(0, 8'h01, 0);
    hi = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy === 1'b1) hi++;
    end
    n_vec++; if (hi != 40) begin n_miss++; $display("FAIL clear_busy_cycles got=%0d exp=40", hi); end
    n_vec++; if (ac !== 7'h00) begin n_miss++; $display("FAIL clear_ac got=%h exp=00", ac); end
    for (int i = 0; i < 32; i++) begin e.idx = i; e.val = mdl_mem[i]; sb.push_back(e); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL clear_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_clear_reset();
    cell_exp_t  e;
    logic [7:0] v;
    int         t;
    lcd_wr(0, 8'hC4, 12);
    for (int i = 0; i < 4; i++) lcd_wr(1, 8'h58, 12);
    sb.delete();
    lcd_wr(0, 8'h01, 0);
    t = 0;
    while (busy !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL clrrst_busy_start got=%b exp=1", busy); end
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL clrrst_busy got=%b exp=0", busy); end
    for (int i = 0; i < 32; i++) begin e.idx = i; e.val = mdl_mem[i]; sb.push_back(e); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      read_cell(e.idx, v);
      n_vec++;
      if (v !== e.val) begin n_miss++; $display("FAIL clrrst_cell[%0d] got=%h exp=%h", e.idx, v, e.val); end
    end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL clrrst_busy_later got=%b exp=0", busy); end
    n_vec++; if (ac !== 7'h00)  begin n_miss++; $display("FAIL clrrst_ac got=%h exp=00", ac); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_text();
    test_readback();
    test_wrap();
    test_busy_violation();
    test_bad_address();
    test_clear();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
